// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-ported, synchronous-read memory.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_gnt,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic pend;
    logic owner;  // 0 = fetch, 1 = data
    logic wr;
  } rsp_t;

  logic       if_win, d_win, force_if;
  logic [3:0] starve_cnt;
  rsp_t       rsp_q, rsp_d;

  // Reset kills both grants, which also blanks the memory command below.
  always_comb begin
    force_if = (starve_cnt == LIMIT);
    d_win    = ~i_rst & i_d_req & ~(i_if_req & force_if);
    if_win   = ~i_rst & i_if_req & ~d_win;
  end

  assign o_if_gnt = if_win;
  assign o_d_gnt  = d_win;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;
    if (if_win) begin
      o_mem_addr = i_if_addr;
      o_mem_ren  = 1'b1;
      o_mem_mask = 4'b1111;
    end else if (d_win) begin
      o_mem_addr  = i_d_addr;
      o_mem_ren   = ~i_d_wen;
      o_mem_wen   = i_d_wen;
      o_mem_wdata = i_d_wdata;
      o_mem_mask  = i_d_mask;
    end
  end

  // Counts data wins while fetch is waiting; any fetch grant or idle fetch clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      starve_cnt <= '0;
    else if (if_win || !i_if_req)
      starve_cnt <= '0;
    else if (d_win && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  always_comb begin
    rsp_d.pend  = if_win | d_win;
    rsp_d.owner = d_win;
    rsp_d.wr    = d_win & i_d_wen;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  // Memory data arrives the cycle after the grant; steer it by the recorded owner.
  always_comb begin
    o_if_valid = rsp_q.pend & ~rsp_q.owner;
    o_d_valid  = rsp_q.pend & rsp_q.owner;
    o_if_rdata = o_if_valid ? i_mem_rdata : '0;
    o_d_rdata  = (o_d_valid && !rsp_q.wr) ? i_mem_rdata : '0;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported, synchronous-read memory between the hart's instruction-fetch port and its data (load/store) port. It sits between the hart and a unified memory, so one memory array can back both instruction and data accesses. It resolves same-cycle conflicts with data priority and bounded fetch starvation, and steers each one-cycle-latency read response back to the requester that issued it.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive data wins allowed while fetch waits before fetch is forced to win; legal range 1..15.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_if_req  in  1  fetch read request.
- i_if_addr  in  32  fetch byte address, word aligned.
- o_if_gnt  out  1  fetch request accepted this cycle.
- o_if_valid  out  1  fetch read data valid.
- o_if_rdata  out  32  fetch read data.
- i_d_req  in  1  data request, read or write.
- i_d_wen  in  1  1 = write, 0 = read; qualified by i_d_req.
- i_d_addr  in  32  data byte address.
- i_d_wdata  in  32  write data.
- i_d_mask  in  4  byte-enable mask, little-endian.
- o_d_gnt  out  1  data request accepted this cycle.
- o_d_valid  out  1  data access complete; read data valid if read.
- o_d_rdata  out  32  data read data; 0 for writes.
- o_mem_addr  out  32  memory address.
- o_mem_ren  out  1  memory read enable.
- o_mem_wen  out  1  memory write enable.
- o_mem_wdata  out  32  memory write data.
- o_mem_mask  out  4  memory byte mask; 4'b1111 for fetch.
- i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_ren.

## Operation
- Grant is combinational in the request cycle. At most one of o_if_gnt and o_d_gnt is high in any cycle.
- Arbitration:
  - Only one requester active: that requester wins.
  - Both active: data wins, unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
- The memory command is driven combinationally from the winner:
  - Fetch winner: addr = i_if_addr, ren = 1, mask = 4'b1111, wdata = 0.
  - Data winner: addr/wdata/mask taken from the data port; ren = ~i_d_wen; wen = i_d_wen.
  - No winner: all memory outputs 0.
- Starvation counter (width 4):
  - Increments, saturating at STARVE_LIMIT, on each cycle where o_d_gnt & i_if_req & ~o_if_gnt.
  - Clears on o_if_gnt, or on any cycle where i_if_req = 0.
- Response pipeline: one registered stage holding rsp_pend, rsp_owner (0 = fetch, 1 = data) and rsp_wr.
  - The stage is loaded every cycle from the current grant.
  - Cycle after a fetch grant: o_if_valid = 1 and o_if_rdata = i_mem_rdata.
  - Cycle after a data read grant: o_d_valid = 1 and o_d_rdata = i_mem_rdata.
  - Cycle after a data write grant: o_d_valid = 1 and o_d_rdata = 0.
  - rdata outputs are 0 whenever the matching valid is low.
- Back-to-back grants every cycle are supported, with no bubble. A response and a new grant may occur in the same cycle.
- A requester holds its request and its address/data stable until it sees its gnt. A request deasserted before grant is dropped, with no side effect.

## Timing
- Grant-to-valid latency is exactly 1 cycle for both ports and for both reads and writes.
- Memory write commits at the grant edge; a read of the same address granted the next cycle returns the new data.
- Reset, asserted asynchronously at any time:
  - Counter = 0 and rsp_pend = 0.
  - o_if_valid, o_d_valid and both rdata outputs go to 0 immediately.
  - While i_rst is high, both gnt outputs and o_mem_ren/o_mem_wen are forced 0.
- Reset mid-operation: any in-flight response is discarded and never presented. The first grant is possible in the first cycle with i_rst low.
- Simultaneous events:
  - Counter at limit and both requesting: fetch wins and the counter clears in the same edge.
  - Data deasserts while fetch waits: fetch wins that cycle.

## Test plan
- Reset: assert i_rst mid-stream, with a fetch response pending -> next cycle o_if_valid = 0, all gnt = 0, mem ren/wen = 0; after release, fetch of 0x0 granted on the first cycle and valid 1 cycle later.
- Fetch only: i_if_req held with addresses 0x0, 0x4, 0x8 on consecutive cycles, memory holding 0x00000013 at each -> grant every cycle; o_if_valid high for 3 consecutive cycles, each with rdata 0x00000013.
- Conflict: both requesting, data read at 0x100 holding 0xDEADBEEF -> o_d_gnt = 1, o_if_gnt = 0; next cycle o_d_valid = 1 and o_d_rdata = 0xDEADBEEF, o_if_valid = 0.
- Starvation, STARVE_LIMIT = 4: both held continuously -> data granted in cycles 1-4, fetch granted in cycle 5, data again in cycle 6; the pattern repeats every 5 cycles.
- Write then read: data write 0x100, wdata 0xA5A5A5A5, mask 4'b0011, then read 0x100 over an initial 0xFFFFFFFF -> o_mem_wen for 1 cycle; write o_d_valid = 1 with rdata 0; read returns 0xFFFFA5A5.
- Dropped request: fetch request raised and lowered while data wins -> no o_if_gnt, no o_if_valid, counter returns to 0.
